// File: rtl/pong_ball_ctrl.sv
// Ping-pong rally controller: serve, ball travel, hit/miss judgement,
// scoring and match end. Drives the 6-bit LED code for the downstream decoder.
module pong_ball_ctrl #(
    parameter int SPEED_DIV  = 4,
    parameter int HIT_ZONE   = 2,
    parameter int POINT_HOLD = 8,
    parameter int WIN_SCORE  = 5
) (
    input  logic       clk_game,
    input  logic       rst_n,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic [5:0] counter,
    output logic [3:0] score_left,
    output logic [3:0] score_right,
    output logic       game_over
);

    typedef enum logic [2:0] {IDLE, MOVE_R, MOVE_L, POINT, GAMEOVER} state_t;

    localparam int STEP_W = (SPEED_DIV > 1) ? $clog2(SPEED_DIV) : 1;
    localparam int HOLD_W = (POINT_HOLD > 1) ? $clog2(POINT_HOLD) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SPEED_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(POINT_HOLD - 1);
    localparam logic [3:0] WIN    = 4'(WIN_SCORE);
    localparam logic [5:0] ZONE_R = 6'(HIT_ZONE);
    localparam logic [5:0] ZONE_L = 6'(17 - HIT_ZONE);

    state_t              state, state_d;
    logic [5:0]          counter_d;
    logic [3:0]          score_left_d, score_right_d;
    logic                game_over_d;
    logic                server_right, server_right_d;   // 0 = left serves
    logic [STEP_W-1:0]   step_cnt, step_cnt_d;
    logic [HOLD_W-1:0]   hold_cnt, hold_cnt_d;
    logic                btn_left_q, btn_right_q;
    logic                press_left, press_right;
    logic                step_tick;
    logic                point_left, point_right;

    assign press_left  = btn_left  & ~btn_left_q;
    assign press_right = btn_right & ~btn_right_q;
    assign step_tick   = (step_cnt == STEP_LAST);

    // State and registered outputs
    always_ff @(posedge clk_game or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            counter      <= '0;
            score_left   <= '0;
            score_right  <= '0;
            game_over    <= 1'b0;
            server_right <= 1'b0;
            step_cnt     <= '0;
            hold_cnt     <= '0;
            btn_left_q   <= 1'b0;
            btn_right_q  <= 1'b0;
        end else begin
            state        <= state_d;
            counter      <= counter_d;
            score_left   <= score_left_d;
            score_right  <= score_right_d;
            game_over    <= game_over_d;
            server_right <= server_right_d;
            step_cnt     <= step_cnt_d;
            hold_cnt     <= hold_cnt_d;
            btn_left_q   <= btn_left;
            btn_right_q  <= btn_right;
        end
    end

    // Next-state, rally judgement and point award
    always_comb begin
        state_d        = state;
        counter_d      = counter;
        score_left_d   = score_left;
        score_right_d  = score_right;
        game_over_d    = game_over;
        server_right_d = server_right;
        step_cnt_d     = step_cnt;
        hold_cnt_d     = hold_cnt;
        point_left     = 1'b0;
        point_right    = 1'b0;

        case (state)
            IDLE: begin
                counter_d = '0;
                if (!server_right && press_left) begin
                    counter_d  = 6'd16;
                    state_d    = MOVE_R;
                    step_cnt_d = '0;
                end else if (server_right && press_right) begin
                    counter_d  = 6'd1;
                    state_d    = MOVE_L;
                    step_cnt_d = '0;
                end
            end
            MOVE_R: begin
                step_cnt_d = step_tick ? '0 : step_cnt + 1'b1;
                // A press takes priority over a coincident step tick
                if (press_right) begin
                    if (counter <= ZONE_R) begin
                        state_d    = MOVE_L;
                        step_cnt_d = '0;
                    end else begin
                        point_left = 1'b1;
                    end
                end else if (step_tick) begin
                    if (counter == 6'd1) point_left = 1'b1;
                    else                 counter_d  = counter - 1'b1;
                end
            end
            MOVE_L: begin
                step_cnt_d = step_tick ? '0 : step_cnt + 1'b1;
                if (press_left) begin
                    if (counter >= ZONE_L) begin
                        state_d    = MOVE_R;
                        step_cnt_d = '0;
                    end else begin
                        point_right = 1'b1;
                    end
                end else if (step_tick) begin
                    if (counter == 6'd16) point_right = 1'b1;
                    else                  counter_d   = counter + 1'b1;
                end
            end
            POINT: begin
                if (hold_cnt == HOLD_LAST) begin
                    if (score_left == WIN || score_right == WIN) begin
                        state_d     = GAMEOVER;
                        counter_d   = 6'd18;
                        game_over_d = 1'b1;
                    end else begin
                        state_d   = IDLE;
                        counter_d = '0;
                    end
                end else begin
                    hold_cnt_d = hold_cnt + 1'b1;
                end
            end
            GAMEOVER: begin
                counter_d   = 6'd18;
                game_over_d = 1'b1;
                if (press_left || press_right) begin
                    score_left_d   = '0;
                    score_right_d  = '0;
                    server_right_d = 1'b0;
                    game_over_d    = 1'b0;
                    counter_d      = '0;
                    state_d        = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                counter_d = '0;
            end
        endcase

        if (point_left) begin
            score_left_d   = (score_left >= WIN) ? WIN : score_left + 1'b1;
            server_right_d = 1'b1;
        end
        if (point_right) begin
            score_right_d  = (score_right >= WIN) ? WIN : score_right + 1'b1;
            server_right_d = 1'b0;
        end
        if (point_left || point_right) begin
            counter_d  = 6'd17;
            hold_cnt_d = '0;
            state_d    = POINT;
        end
    end

endmodule

// File: tb/tb_pong_ball_ctrl.sv
// Directed bench for pong_ball_ctrl with a queue-based scoreboard.
module tb_pong_ball_ctrl;

    localparam int SPEED_DIV  = 4;
    localparam int HIT_ZONE   = 2;
    localparam int POINT_HOLD = 8;
    localparam int WIN_SCORE  = 5;

    logic       clk_game = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic [5:0] counter;
    logic [3:0] score_left, score_right;
    logic       game_over;

    pong_ball_ctrl #(
        .SPEED_DIV (SPEED_DIV),
        .HIT_ZONE  (HIT_ZONE),
        .POINT_HOLD(POINT_HOLD),
        .WIN_SCORE (WIN_SCORE)
    ) dut (
        .clk_game   (clk_game),
        .rst_n      (rst_n),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .counter    (counter),
        .score_left (score_left),
        .score_right(score_right),
        .game_over  (game_over)
    );

    always #5 clk_game = ~clk_game;

    typedef struct {
        string      tag;
        logic [5:0] cnt;
        logic [3:0] sl;
        logic [3:0] sr;
        logic       go;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail = 0;
    int   exp_cnt = 0;
    int   exp_sl = 0;
    int   exp_sr = 0;
    logic exp_go = 1'b0;

    task automatic tick();
        @(posedge clk_game);
        #1;
    endtask

    task automatic expect_now(input string tag);
        exp_t e;
        e.tag = tag;
        e.cnt = 6'(exp_cnt);
        e.sl  = 4'(exp_sl);
        e.sr  = 4'(exp_sr);
        e.go  = exp_go;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        n_assert++;
        assert (sb.size() > 0) else begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed 0 entries, expected at least 1");
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_assert++;
            assert (counter === e.cnt) else begin
                n_fail++;
                $error("FAIL %s counter: observed %0d expected %0d", e.tag, counter, e.cnt);
            end
            n_assert++;
            assert (score_left === e.sl) else begin
                n_fail++;
                $error("FAIL %s score_left: observed %0d expected %0d", e.tag, score_left, e.sl);
            end
            n_assert++;
            assert (score_right === e.sr) else begin
                n_fail++;
                $error("FAIL %s score_right: observed %0d expected %0d", e.tag, score_right, e.sr);
            end
            n_assert++;
            assert (game_over === e.go) else begin
                n_fail++;
                $error("FAIL %s game_over: observed %0b expected %0b", e.tag, game_over, e.go);
            end
        end
    endtask

    // Expectation already set by caller; wait n cycles, then compare
    task automatic run(input string tag, input int n);
        expect_now(tag);
        repeat (n) tick();
        check();
    endtask

    // One-cycle button pulse (right=1 selects btn_right)
    task automatic press(input bit right, input string tag);
        if (right) btn_right = 1'b1;
        else       btn_left  = 1'b1;
        expect_now(tag);
        tick();
        btn_right = 1'b0;
        btn_left  = 1'b0;
        check();
    endtask

    task automatic step_ball(input int dir, input string tag);
        run(tag, SPEED_DIV - 1);
        exp_cnt += dir;
        run(tag, 1);
    endtask

    task automatic steps(input int dir, input int n, input string tag);
        repeat (n) step_ball(dir, tag);
    endtask

    task automatic hold_point(input string tag);
        run(tag, POINT_HOLD - 1);
        if (exp_sl == WIN_SCORE || exp_sr == WIN_SCORE) begin
            exp_cnt = 18;
            exp_go  = 1'b1;
        end else begin
            exp_cnt = 0;
        end
        run(tag, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        rst_n = 1'b0;
        run("reset", 2);
        rst_n = 1'b1;
        run("idle_no_press", 2);

        // Left serve, full descent, right misses at 1
        exp_cnt = 16;
        press(1'b0, "serve_left");
        steps(-1, 15, "descend");
        run("miss_wait", SPEED_DIV - 1);
        exp_cnt = 17; exp_sl = 1;
        run("miss_at_1", 1);
        hold_point("point_hold");
        exp_cnt = 1;
        press(1'b1, "serve_right");

        // Left swings early at 1 while ball heads left
        exp_cnt = 17; exp_sr = 1;
        press(1'b0, "early_left");
        hold_point("point_hold2");

        // Return at 2, return at 15, return on step tick at 1, left misses at 16
        exp_cnt = 16;
        press(1'b0, "serve_left2");
        steps(-1, 14, "to_2");
        press(1'b1, "return_at_2");
        step_ball(1, "after_return");
        steps(1, 12, "to_15");
        press(1'b0, "return_at_15");
        steps(-1, 14, "to_1");
        run("pre_tick", SPEED_DIV - 1);
        press(1'b1, "return_on_tick");
        step_ball(1, "after_tick_return");
        steps(1, 14, "to_16");
        run("miss_wait16", SPEED_DIV - 1);
        exp_cnt = 17; exp_sr = 2;
        run("miss_at_16", 1);
        hold_point("point_hold3");

        // Early right swing at 9, button held through POINT
        exp_cnt = 16;
        press(1'b0, "serve_left3");
        steps(-1, 7, "to_9");
        btn_right = 1'b1;
        exp_cnt = 17; exp_sl = 2;
        run("early_right_9", 1);
        hold_point("held_hold");
        run("held_idle", 2);
        btn_right = 1'b0;
        run("release", 1);

        // Asynchronous reset mid-rally
        exp_cnt = 1;
        press(1'b1, "serve_right2");
        steps(1, 6, "to_7");
        #2;
        rst_n = 1'b0;
        exp_cnt = 0; exp_sl = 0; exp_sr = 0; exp_go = 1'b0;
        expect_now("async_reset");
        #1;
        check();
        run("reset_held", 2);
        rst_n = 1'b1;

        // Left wins five straight points
        exp_cnt = 16;
        press(1'b0, "serve_w1");
        exp_cnt = 17; exp_sl = 1;
        press(1'b1, "early_w1");
        hold_point("hold_w1");
        for (int i = 2; i <= WIN_SCORE; i++) begin
            exp_cnt = 1;
            press(1'b1, "serve_wn");
            steps(1, 15, "climb_wn");
            press(1'b0, "return_16");
            exp_cnt = 17; exp_sl = i;
            press(1'b1, "early_wn");
            hold_point("hold_wn");
        end
        run("gameover_stay", 3);
        exp_cnt = 0; exp_sl = 0; exp_sr = 0; exp_go = 1'b0;
        press(1'b1, "gameover_exit");
        run("gap", 1);
        press(1'b1, "right_not_server");
        exp_cnt = 16;
        press(1'b0, "serve_after_match");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
